// File: rtl/elbeth_csr_file.sv
// elbeth_csr_file
// Machine-mode CSR file. Answers CSR read/write/set/clear commands from the
// decoder, owns the status, trap and counter registers, sequences trap entry
// and ERET, and feeds the current privilege and the redirect target back to
// the pipeline. Reads are combinational and return the pre-update value.

module elbeth_csr_file #(
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  csr_cmd,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic        csr_stall,
  input  logic        retire,
  input  logic        exc_valid,
  input  logic [3:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_badaddr,
  input  logic        eret,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  output logic [1:0]  csr_prv,
  output logic        redirect,
  output logic [31:0] redirect_pc
);

  // Command encodings
  localparam logic [2:0] CMD_IDLE  = 3'd0;
  localparam logic [2:0] CMD_READ  = 3'd4;
  localparam logic [2:0] CMD_WRITE = 3'd5;
  localparam logic [2:0] CMD_SET   = 3'd6;
  localparam logic [2:0] CMD_CLEAR = 3'd7;

  // CSR address map
  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MBADADDR  = 12'h343;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
  localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
  localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
  localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;
  localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

  localparam logic [1:0] PRV_M = 2'b11;
  localparam logic [1:0] PRV_U = 2'b00;

  // Architectural state
  logic [1:0]  prv;
  logic        ie;
  logic [1:0]  prv1;
  logic        ie1;
  logic [31:0] mtvec;
  logic [31:0] mscratch;
  logic [31:0] mepc;
  logic [31:0] mcause;
  logic [31:0] mbadaddr;
  logic [63:0] mcycle;
  logic [63:0] minstret;

  // Decode / control
  logic [31:0] mstatus;
  logic        addr_valid;
  logic        cmd_active;
  logic        cmd_modify;
  logic        wr_en;
  logic [31:0] wr_val;
  logic        trap_take;
  logic        eret_take;
  logic        instret_inc;

  // Read-modify-write result for the three modifying commands; anything else
  // leaves the old value untouched.
  function automatic logic [31:0] csr_update(input logic [2:0]  cmd,
                                             input logic [31:0] old_val,
                                             input logic [31:0] operand);
    logic [31:0] res;
    case (cmd)
      CMD_WRITE: res = operand;
      CMD_SET:   res = old_val | operand;
      CMD_CLEAR: res = old_val & ~operand;
      default:   res = old_val;
    endcase
    return res;
  endfunction

  // Word-aligned addresses: the low two bits never hold state.
  function automatic logic [31:0] word_align(input logic [31:0] val);
    return val & 32'hFFFF_FFFC;
  endfunction

  assign mstatus = {26'd0, prv1, ie1, prv, ie};

  // Combinational read mux and address decode
  always_comb begin
    csr_rdata  = 32'd0;
    addr_valid = 1'b1;
    case (csr_addr)
      ADDR_MSTATUS:                  csr_rdata = mstatus;
      ADDR_MTVEC:                    csr_rdata = mtvec;
      ADDR_MSCRATCH:                 csr_rdata = mscratch;
      ADDR_MEPC:                     csr_rdata = mepc;
      ADDR_MCAUSE:                   csr_rdata = mcause;
      ADDR_MBADADDR:                 csr_rdata = mbadaddr;
      ADDR_MCYCLE,   ADDR_CYCLE:     csr_rdata = mcycle[31:0];
      ADDR_MCYCLEH,  ADDR_CYCLEH:    csr_rdata = mcycle[63:32];
      ADDR_MINSTRET, ADDR_INSTRET:   csr_rdata = minstret[31:0];
      ADDR_MINSTRETH, ADDR_INSTRETH: csr_rdata = minstret[63:32];
      ADDR_MHARTID:                  csr_rdata = HART_ID;
      default:                       addr_valid = 1'b0;
    endcase
  end

  assign cmd_active = (csr_cmd != CMD_IDLE);
  assign cmd_modify = (csr_cmd == CMD_WRITE) || (csr_cmd == CMD_SET) ||
                      (csr_cmd == CMD_CLEAR);

  // Access check: unknown address, insufficient privilege, or a modifying
  // command aimed at the read-only quadrant (addr[11:10] == 2'b11)
  always_comb begin
    csr_illegal = cmd_active &&
                  (!addr_valid ||
                   (prv < csr_addr[9:8]) ||
                   (cmd_modify && (csr_addr[11:10] == 2'b11)));
  end

  // Trap and ERET outrank CSR writes; a stall freezes everything but mcycle
  assign trap_take   = exc_valid && !csr_stall;
  assign eret_take   = eret && !exc_valid && !csr_stall;
  assign wr_en       = cmd_modify && !csr_illegal && !csr_stall && !exc_valid && !eret;
  assign wr_val      = csr_update(csr_cmd, csr_rdata, csr_wdata);
  assign instret_inc = retire && !csr_stall;

  assign csr_prv     = prv;
  assign redirect    = exc_valid | eret;
  assign redirect_pc = exc_valid ? mtvec : mepc;

  // Privilege/interrupt-enable stack: push on trap, pop on ERET
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prv  <= PRV_M;
      ie   <= 1'b0;
      prv1 <= PRV_U;
      ie1  <= 1'b0;
    end else if (trap_take) begin
      prv1 <= prv;
      ie1  <= ie;
      prv  <= PRV_M;
      ie   <= 1'b0;
    end else if (eret_take) begin
      prv  <= prv1;
      ie   <= ie1;
      prv1 <= PRV_U;
      ie1  <= 1'b1;
    end else if (wr_en && (csr_addr == ADDR_MSTATUS)) begin
      ie   <= wr_val[0];
      prv  <= wr_val[2:1];
      ie1  <= wr_val[3];
      prv1 <= wr_val[5:4];
    end
  end

  // Trap record registers: captured on trap entry, otherwise software-writable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mepc     <= 32'd0;
      mcause   <= 32'd0;
      mbadaddr <= 32'd0;
    end else if (trap_take) begin
      mepc     <= word_align(exc_pc);
      mcause   <= {28'd0, exc_code};
      mbadaddr <= exc_badaddr;
    end else if (wr_en) begin
      if (csr_addr == ADDR_MEPC)     mepc     <= word_align(wr_val);
      if (csr_addr == ADDR_MCAUSE)   mcause   <= wr_val;
      if (csr_addr == ADDR_MBADADDR) mbadaddr <= wr_val;
    end
  end

  // Plain software-writable registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtvec    <= MTVEC_RESET & 32'hFFFF_FFFC;
      mscratch <= 32'd0;
    end else if (wr_en) begin
      if (csr_addr == ADDR_MTVEC)    mtvec    <= word_align(wr_val);
      if (csr_addr == ADDR_MSCRATCH) mscratch <= wr_val;
    end
  end

  // Cycle counter: free-running even under stall; a write to one half
  // replaces that half and freezes the other for this cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcycle <= 64'd0;
    end else if (wr_en && (csr_addr == ADDR_MCYCLE)) begin
      mcycle <= {mcycle[63:32], wr_val};
    end else if (wr_en && (csr_addr == ADDR_MCYCLEH)) begin
      mcycle <= {wr_val, mcycle[31:0]};
    end else begin
      mcycle <= mcycle + 64'd1;
    end
  end

  // Retired-instruction counter: same write rule, counts only unstalled retires
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      minstret <= 64'd0;
    end else if (wr_en && (csr_addr == ADDR_MINSTRET)) begin
      minstret <= {minstret[63:32], wr_val};
    end else if (wr_en && (csr_addr == ADDR_MINSTRETH)) begin
      minstret <= {wr_val, minstret[31:0]};
    end else if (instret_inc) begin
      minstret <= minstret + 64'd1;
    end
  end

endmodule

// File: tb/tb_elbeth_csr_file.sv
// tb_elbeth_csr_file
// Directed bench for the machine-mode CSR file. Inputs change 1 ns after the
// rising edge; combinational outputs are sampled 1 ns after inputs settle.

module tb_elbeth_csr_file;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READ  = 3'd4;
  localparam logic [2:0] WRITE = 3'd5;
  localparam logic [2:0] SET   = 3'd6;
  localparam logic [2:0] CLEAR = 3'd7;

  logic        clk;
  logic        rst;
  logic [2:0]  csr_cmd;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_stall;
  logic        retire;
  logic        exc_valid;
  logic [3:0]  exc_code;
  logic [31:0] exc_pc;
  logic [31:0] exc_badaddr;
  logic        eret;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic [1:0]  csr_prv;
  logic        redirect;
  logic [31:0] redirect_pc;

  int errors = 0;
  int checks = 0;

  elbeth_csr_file #(
    .HART_ID     (32'd0),
    .MTVEC_RESET (32'h0000_0100)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .csr_cmd     (csr_cmd),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .csr_stall   (csr_stall),
    .retire      (retire),
    .exc_valid   (exc_valid),
    .exc_code    (exc_code),
    .exc_pc      (exc_pc),
    .exc_badaddr (exc_badaddr),
    .eret        (eret),
    .csr_rdata   (csr_rdata),
    .csr_illegal (csr_illegal),
    .csr_prv     (csr_prv),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Put a command on the bus and let the combinational outputs settle
  task automatic drive(input logic [2:0] cmd, input logic [11:0] addr, input logic [31:0] wd);
    csr_cmd   = cmd;
    csr_addr  = addr;
    csr_wdata = wd;
    #1;
  endtask

  task automatic idle_inputs();
    csr_cmd     = IDLE;
    csr_addr    = 12'h000;
    csr_wdata   = 32'd0;
    csr_stall   = 1'b0;
    retire      = 1'b0;
    exc_valid   = 1'b0;
    exc_code    = 4'd0;
    exc_pc      = 32'd0;
    exc_badaddr = 32'd0;
    eret        = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (3) tick();
    checks++; if (csr_prv !== 2'b11) begin errors++; $display("FAIL reset_prv got=%0d exp=3", csr_prv); end
    checks++; if (csr_illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got=%b exp=0", csr_illegal); end
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL reset_redirect got=%b exp=0", redirect); end
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_redirect_pc got=%h exp=00000000", redirect_pc); end
    rst = 1'b1;
    tick();
    drive(READ, 12'h300, 32'd0);
    checks++; if (csr_rdata !== 32'h6) begin errors++; $display("FAIL reset_mstatus got=%h exp=00000006", csr_rdata); end
    checks++; if (csr_illegal !== 1'b0) begin errors++; $display("FAIL reset_mstatus_legal got=%b exp=0", csr_illegal); end
    drive(READ, 12'h305, 32'd0);
    checks++; if (csr_rdata !== 32'h100) begin errors++; $display("FAIL reset_mtvec got=%h exp=00000100", csr_rdata); end
    drive(READ, 12'hF14, 32'd0);
    checks++; if (csr_rdata !== 32'h0 || csr_illegal !== 1'b0) begin errors++; $display("FAIL mhartid got=%h ill=%b exp=00000000 ill=0", csr_rdata, csr_illegal); end
    drive(READ, 12'h7C0, 32'd0);
    checks++; if (csr_illegal !== 1'b1) begin errors++; $display("FAIL unimpl_addr_illegal got=%b exp=1", csr_illegal); end
    drive(WRITE, 12'hF14, 32'h5);
    checks++; if (csr_illegal !== 1'b1) begin errors++; $display("FAIL write_ro_illegal got=%b exp=1", csr_illegal); end
    drive(IDLE, 12'h7C0, 32'd0);
    checks++; if (csr_illegal !== 1'b0) begin errors++; $display("FAIL idle_not_illegal got=%b exp=0", csr_illegal); end
  endtask

  task automatic test_rw_set_clear();
    drive(WRITE, 12'h340, 32'hA5A5_0000);
    tick();
    drive(READ, 12'h340, 32'd0);
    checks++; if (csr_rdata !== 32'hA5A5_0000) begin errors++; $display("FAIL mscratch_write got=%h exp=a5a50000", csr_rdata); end
    drive(SET, 12'h340, 32'h0000_00FF);
    checks++; if (csr_rdata !== 32'hA5A5_0000) begin errors++; $display("FAIL set_returns_old got=%h exp=a5a50000", csr_rdata); end
    tick();
    drive(READ, 12'h340, 32'd0);
    checks++; if (csr_rdata !== 32'hA5A5_00FF) begin errors++; $display("FAIL mscratch_set got=%h exp=a5a500ff", csr_rdata); end
    drive(CLEAR, 12'h340, 32'hA500_0000);
    tick();
    drive(READ, 12'h340, 32'd0);
    checks++; if (csr_rdata !== 32'h00A5_00FF) begin errors++; $display("FAIL mscratch_clear got=%h exp=00a500ff", csr_rdata); end
  endtask

  task automatic test_hardwired_bits();
    drive(WRITE, 12'h305, 32'h0000_0203);
    tick();
    drive(READ, 12'h305, 32'd0);
    checks++; if (csr_rdata !== 32'h0000_0200) begin errors++; $display("FAIL mtvec_align got=%h exp=00000200", csr_rdata); end
    drive(SET, 12'h305, 32'h0000_0003);
    tick();
    drive(READ, 12'h305, 32'd0);
    checks++; if (csr_rdata !== 32'h0000_0200) begin errors++; $display("FAIL mtvec_set_align got=%h exp=00000200", csr_rdata); end
    drive(WRITE, 12'h341, 32'h0000_0107);
    tick();
    drive(READ, 12'h341, 32'd0);
    checks++; if (csr_rdata !== 32'h0000_0104) begin errors++; $display("FAIL mepc_align got=%h exp=00000104", csr_rdata); end
    drive(WRITE, 12'h305, 32'h0000_0100);
    tick();
    drive(READ, 12'h305, 32'd0);
    checks++; if (csr_rdata !== 32'h0000_0100) begin errors++; $display("FAIL mtvec_restore got=%h exp=00000100", csr_rdata); end
  endtask

  task automatic test_counter_wrap();
    drive(WRITE, 12'hB00, 32'hFFFF_FFFF);
    tick();
    drive(WRITE, 12'hB80, 32'hFFFF_FFFF);
    tick();
    drive(READ, 12'hB00, 32'd0);
    checks++; if (csr_rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mcycle_lo_hold got=%h exp=ffffffff", csr_rdata); end
    drive(READ, 12'hB80, 32'd0);
    checks++; if (csr_rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mcycle_hi_written got=%h exp=ffffffff", csr_rdata); end
    tick();
    drive(READ, 12'hC00, 32'd0);
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL cycle_wrap_lo got=%h exp=00000000", csr_rdata); end
    drive(READ, 12'hC80, 32'd0);
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL cycle_wrap_hi got=%h exp=00000000", csr_rdata); end
    tick();
    drive(READ, 12'hC00, 32'd0);
    checks++; if (csr_rdata !== 32'h1) begin errors++; $display("FAIL cycle_after_wrap got=%h exp=00000001", csr_rdata); end
    drive(WRITE, 12'hC00, 32'h0000_0055);
    checks++; if (csr_illegal !== 1'b1) begin errors++; $display("FAIL cycle_alias_ro got=%b exp=1", csr_illegal); end
    tick();
    drive(READ, 12'hB00, 32'd0);
    checks++; if (csr_rdata !== 32'h2) begin errors++; $display("FAIL cycle_unaffected got=%h exp=00000002", csr_rdata); end
    // minstret: writes race a retire; the dropped increment must not carry
    retire = 1'b1;
    drive(WRITE, 12'hB02, 32'hFFFF_FFFF);
    tick();
    drive(WRITE, 12'hB82, 32'hFFFF_FFFF);
    tick();
    drive(READ, 12'hB02, 32'd0);
    checks++; if (csr_rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL minstret_lo_hold got=%h exp=ffffffff", csr_rdata); end
    tick();
    retire = 1'b0;
    drive(READ, 12'hC02, 32'd0);
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL instret_wrap_lo got=%h exp=00000000", csr_rdata); end
    drive(READ, 12'hC82, 32'd0);
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL instret_wrap_hi got=%h exp=00000000", csr_rdata); end
    tick();
    drive(READ, 12'hB02, 32'd0);
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL minstret_no_retire got=%h exp=00000000", csr_rdata); end
  endtask

  task automatic test_trap();
    exc_valid   = 1'b1;
    exc_code    = 4'd2;
    exc_pc      = 32'h0000_0203;
    exc_badaddr = 32'hDEAD_BEEF;
    drive(WRITE, 12'h340, 32'h1234_5678);
    checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL trap_redirect got=%b exp=1", redirect); end
    checks++; if (redirect_pc !== 32'h100) begin errors++; $display("FAIL trap_redirect_pc got=%h exp=00000100", redirect_pc); end
    tick();
    exc_valid = 1'b0;
    drive(READ, 12'h341, 32'd0);
    checks++; if (csr_rdata !== 32'h200) begin errors++; $display("FAIL trap_mepc got=%h exp=00000200", csr_rdata); end
    drive(READ, 12'h342, 32'd0);
    checks++; if (csr_rdata !== 32'h2) begin errors++; $display("FAIL trap_mcause got=%h exp=00000002", csr_rdata); end
    drive(READ, 12'h343, 32'd0);
    checks++; if (csr_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL trap_mbadaddr got=%h exp=deadbeef", csr_rdata); end
    drive(READ, 12'h300, 32'd0);
    checks++; if (csr_rdata !== 32'h36) begin errors++; $display("FAIL trap_mstatus got=%h exp=00000036", csr_rdata); end
    checks++; if (csr_prv !== 2'b11) begin errors++; $display("FAIL trap_prv got=%0d exp=3", csr_prv); end
    drive(READ, 12'h340, 32'd0);
    checks++; if (csr_rdata !== 32'h00A5_00FF) begin errors++; $display("FAIL trap_mscratch_kept got=%h exp=00a500ff", csr_rdata); end
  endtask

  task automatic test_eret();
    drive(WRITE, 12'h300, 32'h6);
    tick();
    drive(READ, 12'h300, 32'd0);
    checks++; if (csr_rdata !== 32'h6) begin errors++; $display("FAIL eret_mstatus_setup got=%h exp=00000006", csr_rdata); end
    eret = 1'b1;
    drive(IDLE, 12'h000, 32'd0);
    checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h200) begin errors++; $display("FAIL eret_redirect got=%b/%h exp=1/00000200", redirect, redirect_pc); end
    tick();
    eret = 1'b0;
    drive(IDLE, 12'h000, 32'd0);
    checks++; if (csr_prv !== 2'b00) begin errors++; $display("FAIL eret_prv got=%0d exp=0", csr_prv); end
    drive(READ, 12'h300, 32'd0);
    checks++; if (csr_illegal !== 1'b1) begin errors++; $display("FAIL user_mstatus_illegal got=%b exp=1", csr_illegal); end
    drive(READ, 12'hC00, 32'd0);
    checks++; if (csr_illegal !== 1'b0) begin errors++; $display("FAIL user_cycle_legal got=%b exp=0", csr_illegal); end
  endtask

  task automatic test_stall_and_reset();
    // Clean slate via an asynchronous reset pulse between edges
    drive(IDLE, 12'h000, 32'd0);
    rst = 1'b0;
    #1;
    checks++; if (csr_prv !== 2'b11) begin errors++; $display("FAIL async_reset_prv got=%0d exp=3", csr_prv); end
    #1;
    rst = 1'b1;
    tick();
    drive(WRITE, 12'h340, 32'h0000_1111);
    tick();
    retire = 1'b1;
    drive(WRITE, 12'hB00, 32'h0000_1000);
    tick();
    csr_stall = 1'b1;
    drive(WRITE, 12'h340, 32'h0000_2222);
    tick();
    retire = 1'b0;
    exc_valid = 1'b1;
    exc_code  = 4'd7;
    drive(IDLE, 12'h000, 32'd0);
    checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL stalled_exc_redirect got=%b exp=1", redirect); end
    tick();
    exc_valid = 1'b0;
    csr_stall = 1'b0;
    drive(READ, 12'h340, 32'd0);
    checks++; if (csr_rdata !== 32'h1111) begin errors++; $display("FAIL stall_mscratch got=%h exp=00001111", csr_rdata); end
    drive(READ, 12'hB02, 32'd0);
    checks++; if (csr_rdata !== 32'h1) begin errors++; $display("FAIL stall_minstret got=%h exp=00000001", csr_rdata); end
    drive(READ, 12'hB00, 32'd0);
    checks++; if (csr_rdata !== 32'h1002) begin errors++; $display("FAIL stall_mcycle got=%h exp=00001002", csr_rdata); end
    drive(READ, 12'h342, 32'd0);
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL stall_trap_blocked got=%h exp=00000000", csr_rdata); end
    drive(WRITE, 12'h305, 32'h0000_0400);
    tick();
    drive(READ, 12'h305, 32'd0);
    checks++; if (csr_rdata !== 32'h400) begin errors++; $display("FAIL mtvec_pre_reset got=%h exp=00000400", csr_rdata); end
    // Reset lands mid-cycle: state must clear without waiting for an edge
    rst = 1'b0;
    #1;
    drive(READ, 12'h305, 32'd0);
    checks++; if (csr_rdata !== 32'h100) begin errors++; $display("FAIL midreset_mtvec got=%h exp=00000100", csr_rdata); end
    drive(READ, 12'h340, 32'd0);
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL midreset_mscratch got=%h exp=00000000", csr_rdata); end
    drive(READ, 12'hB00, 32'd0);
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL midreset_mcycle got=%h exp=00000000", csr_rdata); end
    drive(READ, 12'hB02, 32'd0);
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL midreset_minstret got=%h exp=00000000", csr_rdata); end
    drive(READ, 12'h300, 32'd0);
    checks++; if (csr_rdata !== 32'h6) begin errors++; $display("FAIL midreset_mstatus got=%h exp=00000006", csr_rdata); end
    rst = 1'b1;
    idle_inputs();
    tick();
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_rw_set_clear();
    test_hardwired_bits();
    test_counter_wrap();
    test_trap();
    test_eret();
    test_stall_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
